sa_edge_feeder: RTL and testbench

Drives the west and north edges of the N×N systolic MAC array. It accepts one A-row-slice/B-column-slice vector pair per cycle through a valid/ready handshake and sequences a clear beat, K data beats and one flush beat. Every lane is skewed so that each PE receives `clr`, `we` and operands with the alignment its 2-stage MAC pipeline requires. It is the transmitting end of the PE operand/control chain and sits between the operand buffers and the array.

---
 rtl/sa_edge_feeder.sv | 169 ++++++++++++++++
 tb/tb_sa_edge_feeder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_edge_feeder.sv
// sa_edge_feeder: west/north edge driver for an ARRAY_N x ARRAY_N systolic MAC array.
// Each tile is issued as one clear beat, K data beats (with bubbles while the
// source stalls), one flush beat and an N+1 cycle drain. Lane r is then skewed:
// control reaches lane r r+1 cycles after issue, and operands arrive one cycle later.
module sa_edge_feeder #(
  parameter int ARRAY_N    = 4,   // must be >= 2
  parameter int K_W        = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [K_W-1:0]                k_len_i,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] a_vec_i,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] b_vec_i,
  input  logic                          vec_valid_i,
  output logic                          vec_ready_o,
  output logic [ARRAY_N*DATA_WIDTH-1:0] srca_o,
  output logic [ARRAY_N*DATA_WIDTH-1:0] srcb_o,
  output logic [ARRAY_N-1:0]            clr_o,
  output logic [ARRAY_N-1:0]            we_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int VW   = ARRAY_N * DATA_WIDTH;
  localparam int DC_W = $clog2(ARRAY_N + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;
  logic [K_W-1:0]  cnt_q, cnt_d;
  logic [DC_W-1:0] drain_q, drain_d;
  logic            done_q, done_d;

  // The beat issued in the current cycle, before skewing.
  logic            beat_we;
  logic            beat_clr;
  logic [VW-1:0]   beat_a;
  logic [VW-1:0]   beat_b;

  // Control skew chain: bit r carries the beat issued r+1 cycles ago.
  logic [ARRAY_N-1:0] we_sr_q;
  logic [ARRAY_N-1:0] clr_sr_q;

  // Ready depends on state only, so the source never sees a valid->ready loop.
  assign vec_ready_o = (state_q == S_FEED);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign we_o        = we_sr_q;
  assign clr_o       = clr_sr_q;

  // State, latched length, beat counter, drain counter and done pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and the beat issued this cycle.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    beat_we  = 1'b0;
    beat_clr = 1'b0;
    beat_a   = '0;
    beat_b   = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          k_d     = k_len_i;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        beat_clr = 1'b1;
        state_d  = (k_q == '0) ? S_FLUSH : S_FEED;
      end
      S_FEED: begin
        // A missing vector becomes a bubble beat: we=0 and zero operands.
        if (vec_valid_i) begin
          beat_we = 1'b1;
          beat_a  = a_vec_i;
          beat_b  = b_vec_i;
          cnt_d   = cnt_q + K_W'(1);
          if (cnt_d == k_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Extra enable with zero data pushes the last product into psum.
        beat_we = 1'b1;
        drain_d = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == DC_W'(ARRAY_N)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control skew: lane 0 sees the beat one cycle after issue, each next lane one more.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_sr_q  <= '0;
      clr_sr_q <= '0;
    end else begin
      we_sr_q  <= ARRAY_N'({we_sr_q, beat_we});
      clr_sr_q <= ARRAY_N'({clr_sr_q, beat_clr});
    end
  end

  // Per-lane operand skew: lane gi is delayed gi+2 cycles, one behind its enable.
  for (genvar gi = 0; gi < ARRAY_N; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_sr_q [gi+2];
    logic [DATA_WIDTH-1:0] b_sr_q [gi+2];

    // Shift this lane's operand slices toward the array edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j < gi + 2; j++) begin
          a_sr_q[j] <= '0;
          b_sr_q[j] <= '0;
        end
      end else begin
        a_sr_q[0] <= beat_a[gi*DATA_WIDTH +: DATA_WIDTH];
        b_sr_q[0] <= beat_b[gi*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j < gi + 2; j++) begin
          a_sr_q[j] <= a_sr_q[j-1];
          b_sr_q[j] <= b_sr_q[j-1];
        end
      end
    end

    assign srca_o[gi*DATA_WIDTH +: DATA_WIDTH] = a_sr_q[gi+1];
    assign srcb_o[gi*DATA_WIDTH +: DATA_WIDTH] = b_sr_q[gi+1];
  end

endmodule

// File: tb/tb_sa_edge_feeder.sv
// tb_sa_edge_feeder: random and directed tiles against a cycle-indexed beat model.
// The model records which beat each cycle should issue (from the tile rules),
// and expected outputs are read back from that record with the lane skews applied.
module tb_sa_edge_feeder;
  localparam int N    = 4;
  localparam int KW   = 8;
  localparam int DW   = 16;
  localparam int VW   = N * DW;
  localparam int HMAX = 4096;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          start_i = 1'b0;
  logic [KW-1:0] k_len_i = '0;
  logic [VW-1:0] a_vec_i = '0;
  logic [VW-1:0] b_vec_i = '0;
  logic          vec_valid_i = 1'b0;
  logic          vec_ready_o;
  logic [VW-1:0] srca_o;
  logic [VW-1:0] srcb_o;
  logic [N-1:0]  clr_o;
  logic [N-1:0]  we_o;
  logic          busy_o;
  logic          done_o;

  sa_edge_feeder #(.ARRAY_N(N), .K_W(KW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i),
    .a_vec_i(a_vec_i), .b_vec_i(b_vec_i), .vec_valid_i(vec_valid_i),
    .vec_ready_o(vec_ready_o), .srca_o(srca_o), .srcb_o(srcb_o),
    .clr_o(clr_o), .we_o(we_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hist_base = 0;

  // Beat record per cycle, and a few observed outputs for spot checks.
  bit            h_we  [HMAX];
  bit            h_clr [HMAX];
  logic [VW-1:0] h_a   [HMAX];
  logic [VW-1:0] h_b   [HMAX];
  logic [N-1:0]  o_we  [HMAX];
  logic [N-1:0]  o_clr [HMAX];
  logic [DW-1:0] o_a3  [HMAX];
  bit            o_rdy [HMAX];
  bit            o_done[HMAX];

  // Tile model
  bit m_active = 0;
  int m_s, m_k, m_hs_left, m_stalls;
  int m_flush = -1;
  int m_done_cyc = -1;
  bit m_last_valid = 0;
  int m_last_s, m_last_k, m_last_stalls;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit hist_we(input int idx);
    if (idx < 0 || idx < hist_base) return 1'b0;
    return h_we[idx];
  endfunction

  function automatic bit hist_clr(input int idx);
    if (idx < 0 || idx < hist_base) return 1'b0;
    return h_clr[idx];
  endfunction

  function automatic logic [VW-1:0] hist_a(input int idx);
    if (idx < 0 || idx < hist_base) return '0;
    return h_a[idx];
  endfunction

  function automatic logic [VW-1:0] hist_b(input int idx);
    if (idx < 0 || idx < hist_base) return '0;
    return h_b[idx];
  endfunction

  // One clock cycle: check outputs for this cycle, drive inputs, record the model beat.
  task automatic step(input bit st, input int k, input bit vv,
                      input logic [VW-1:0] av, input logic [VW-1:0] bv);
    logic [N-1:0]  ew, ec;
    logic [VW-1:0] ea, eb, ta, tb;
    bit            b_we, b_clr;
    logic [VW-1:0] b_a, b_b;
    @(negedge clk_i);
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget: got %0d, limit %0d", cyc, HMAX);
      $fatal(1, "history exhausted");
    end
    for (int r = 0; r < N; r++) begin
      ew[r] = hist_we(cyc - 1 - r);
      ec[r] = hist_clr(cyc - 1 - r);
      ta = hist_a(cyc - 2 - r);
      tb = hist_b(cyc - 2 - r);
      ea[r*DW +: DW] = ta[r*DW +: DW];
      eb[r*DW +: DW] = tb[r*DW +: DW];
    end
    check("we", 64'(we_o), 64'(ew));
    check("clr", 64'(clr_o), 64'(ec));
    check("srca", srca_o, ea);
    check("srcb", srcb_o, eb);
    check("busy", 64'(busy_o), 64'(m_active));
    check("ready", 64'(vec_ready_o), 64'(m_active && cyc > m_s + 1 && m_flush < 0));
    check("done", 64'(done_o), 64'(cyc == m_done_cyc));
    o_we[cyc] = we_o; o_clr[cyc] = clr_o; o_a3[cyc] = srca_o[3*DW +: DW];
    o_rdy[cyc] = vec_ready_o; o_done[cyc] = done_o;
    if (done_o === 1'b1 && m_last_valid) begin
      check("latency", 64'(cyc - m_last_s), 64'(3 + m_last_k + m_last_stalls + N + 1));
      $display("tile: start=%0d k=%0d stalls=%0d done=%0d", m_last_s, m_last_k, m_last_stalls, cyc);
      m_last_valid = 0;
    end

    start_i = st; k_len_i = KW'(k); vec_valid_i = vv; a_vec_i = av; b_vec_i = bv;

    b_we = 0; b_clr = 0; b_a = '0; b_b = '0;
    if (rst_ni) begin
      if (!m_active) begin
        if (st) begin
          m_active = 1; m_s = cyc; m_k = k; m_hs_left = k; m_flush = -1; m_stalls = 0;
        end
      end else if (cyc == m_s + 1) begin
        b_clr = 1;
        if (m_hs_left == 0) m_flush = cyc + 1;
      end else if (m_flush < 0) begin
        if (vv) begin
          b_we = 1; b_a = av; b_b = bv;
          m_hs_left--;
          if (m_hs_left == 0) m_flush = cyc + 1;
        end else begin
          m_stalls++;
        end
      end else if (cyc == m_flush) begin
        b_we = 1;
      end else if (cyc == m_flush + N + 1) begin
        m_active = 0; m_done_cyc = cyc + 1;
        m_last_valid = 1; m_last_s = m_s; m_last_k = m_k; m_last_stalls = m_stalls;
      end
    end
    h_we[cyc] = b_we; h_clr[cyc] = b_clr; h_a[cyc] = b_a; h_b[cyc] = b_b;
    cyc++;
  endtask

  function automatic logic [VW-1:0] rvec();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (m_active && n < 300) begin
      step(1'b0, 0, 1'b1, rvec(), rvec());
      n++;
    end
    check(tag, 64'(m_active), 64'd0);
  endtask

  logic [VW-1:0] a_basic, b_basic;
  int c0, c1, c2;
  bit any_rdy;

  initial begin
    for (int r = 0; r < N; r++) begin
      a_basic[r*DW +: DW] = DW'(r + 1);
      b_basic[r*DW +: DW] = DW'(16 * (r + 1));
    end
    #1 rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, '0, '0);
    rst_ni = 1'b1;
    step(1'b0, 0, 1'b0, '0, '0);

    // Basic tile K=3, vectors at relative cycles 2-4.
    c0 = cyc;
    for (int i = 0; i < 11; i++) step(i == 0, 3, (i >= 2 && i <= 4), a_basic, b_basic);
    // K=0 tile started on the done cycle; valid held high must be ignored.
    c1 = cyc;
    for (int i = 0; i < 8; i++) step(i == 0, 0, 1'b1, a_basic, b_basic);
    // K=2 with a two-cycle stall; a start during FEED asks for K=7 and is dropped.
    c2 = cyc;
    for (int i = 0; i < 13; i++) step(i == 0 || i == 3, (i == 3) ? 7 : 2, (i == 2 || i == 5), rvec(), rvec());
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, '0, '0);

    check("bt_clr0@2", 64'(o_clr[c0+2][0]), 64'd1);
    check("bt_clr0@3", 64'(o_clr[c0+3][0]), 64'd0);
    check("bt_clr3@5", 64'(o_clr[c0+5][3]), 64'd1);
    check("bt_we0@2", 64'(o_we[c0+2][0]), 64'd0);
    for (int t = 3; t <= 6; t++) check("bt_we0", 64'(o_we[c0+t][0]), 64'd1);
    check("bt_we0@7", 64'(o_we[c0+7][0]), 64'd0);
    for (int t = 6; t <= 9; t++) check("bt_we3", 64'(o_we[c0+t][3]), 64'd1);
    check("bt_we3@10", 64'(o_we[c0+10][3]), 64'd0);
    for (int t = 7; t <= 9; t++) check("bt_a3", 64'(o_a3[c0+t]), 64'h0004);
    check("bt_a3@10", 64'(o_a3[c0+10]), 64'd0);
    check("bt_done@10", 64'(o_done[c0+10]), 64'd0);
    check("bt_done@11", 64'(o_done[c0+11]), 64'd1);
    check("k0_clr0", 64'(o_clr[c1+2][0]), 64'd1);
    check("k0_we0", 64'(o_we[c1+3][0]), 64'd1);
    check("k0_we0_once", 64'(o_we[c1+4][0]), 64'd0);
    check("k0_done", 64'(o_done[c1+8]), 64'd1);
    any_rdy = 0;
    for (int t = 0; t <= 8; t++) any_rdy |= o_rdy[c1+t];
    check("k0_no_ready", 64'(any_rdy), 64'd0);
    check("st_we0_hs", 64'(o_we[c2+3][0]), 64'd1);
    check("st_we0_bub", 64'(o_we[c2+4][0] | o_we[c2+5][0]), 64'd0);
    check("st_we3_bub", 64'(o_we[c2+7][3] | o_we[c2+8][3]), 64'd0);
    check("st_we3_hs", 64'(o_we[c2+9][3]), 64'd1);
    check("st_done", 64'(o_done[c2+12]), 64'd1);

    // Random tiles, including starts while busy.
    for (int i = 0; i < 1200; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 6), $urandom_range(0, 9) < 7, rvec(), rvec());
    wait_idle("idle_before_reset");

    // Asynchronous reset in the middle of FEED.
    for (int i = 0; i < 4; i++) step(i == 0, 6, 1'b0, rvec(), rvec());
    check("feed_before_reset", 64'(vec_ready_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_we", 64'(we_o), 64'd0);
    check("rst_clr", 64'(clr_o), 64'd0);
    check("rst_srca", srca_o, 64'd0);
    check("rst_srcb", srcb_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ready", 64'(vec_ready_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    m_active = 0; m_done_cyc = -1; m_flush = -1; m_last_valid = 0;
    hist_base = cyc;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, '0, '0);
    rst_ni = 1'b1;
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5), $urandom_range(0, 9) < 6, rvec(), rvec());
    wait_idle("idle_at_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
